// File: rtl/lfsr_pkg.sv
// lfsr_pkg
// Shared definitions for the LFSR run controller: datapath widths, the
// period-measure timeout, FSM state encoding, run-mode encoding and the
// 4-bit LFSR step function (taps on bits 1 and 0, maximal period 15).
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam int CNT_W  = 8;

  // Shift count at which a period measurement gives up.
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(255);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  typedef enum logic [1:0] {
    MODE_STEP    = 2'b00,
    MODE_PERIOD  = 2'b01,
    MODE_FREE    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_t;

  // Right shift with the feedback bit (bit1 ^ bit0) entering at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[1] ^ s[0], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core
// 4-bit Fibonacci-style shift register.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous reset, active low; clears the register
//   load  - parallel load of seed (takes priority over en)
//   en    - advance one LFSR step
//   seed  - value loaded when load is high
//   state - current register contents
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl
// Run controller around lfsr_core. A run is requested with start in IDLE and
// executes in one of three modes: step-N (shift nsteps times), period-measure
// (shift until the register returns to its seed) or free-run (shift until
// stop). Bad requests (zero seed or illegal mode) are rejected with err.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active low
//   start  - run request, sampled only in IDLE
//   mode   - 00 step-N, 01 period-measure, 10 free-run, 11 illegal
//   seed   - initial LFSR value (must be non-zero)
//   nsteps - shift count for step-N
//   stop   - abort / finish a run while in RUN
//   state  - current LFSR contents
//   count  - shifts performed in the current or last run
//   busy   - high in LOAD and RUN
//   done   - one-cycle pulse at run end
//   err    - one-cycle pulse on rejected start or period timeout
module lfsr_ctrl
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  nsteps,
  input  logic              stop,
  output logic [LFSR_W-1:0] state,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  fsm_t              fsm;
  mode_t             mode_l;
  logic [LFSR_W-1:0] seed_l;
  logic [CNT_W-1:0]  nsteps_l;

  logic [CNT_W-1:0]  cnt_inc;
  logic              term;
  logic              timeout;
  logic              core_load;
  logic              core_en;

  lfsr_core u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (core_load),
    .en    (core_en),
    .seed  (seed_l),
    .state (state)
  );

  // Terminal-condition decode for the current RUN cycle. A terminal shift is
  // always performed, even if stop arrives in the same cycle.
  always_comb begin
    cnt_inc = count + CNT_W'(1);
    term    = 1'b0;
    timeout = 1'b0;
    if (fsm == RUN) begin
      case (mode_l)
        MODE_STEP:   term = (cnt_inc == nsteps_l);
        MODE_PERIOD: begin
          if (lfsr_next(state) == seed_l) begin
            term = 1'b1;
          end else if (cnt_inc == TIMEOUT) begin
            term    = 1'b1;
            timeout = 1'b1;
          end
        end
        default: ;
      endcase
    end
    core_load = (fsm == LOAD);
    core_en   = (fsm == RUN) && (term || !stop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm      <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mode_l   <= MODE_STEP;
      seed_l   <= '0;
      nsteps_l <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            if ((seed != '0) && (mode != MODE_ILLEGAL)) begin
              mode_l   <= mode_t'(mode);
              seed_l   <= seed;
              nsteps_l <= nsteps;
              busy     <= 1'b1;
              fsm      <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          count <= '0;
          if ((mode_l == MODE_STEP) && (nsteps_l == '0)) begin
            busy <= 1'b0;
            done <= 1'b1;
            fsm  <= DONE;
          end else begin
            fsm <= RUN;
          end
        end
        RUN: begin
          if (term) begin
            count <= cnt_inc;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= timeout;
            fsm   <= DONE;
          end else if (stop) begin
            busy <= 1'b0;
            done <= 1'b1;
            fsm  <= DONE;
          end else if (count != '1) begin
            // Saturate in free-run; the register itself keeps shifting.
            count <= cnt_inc;
          end
        end
        DONE: begin
          fsm <= IDLE;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl
// Bench for lfsr_ctrl: reset state, a table of directed runs with
// hand-computed results, hand-written rejection and reset-mid-run sequences,
// and randomized runs checked against a sequence-level reference model.
module tb_lfsr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] seed;
  logic [7:0] nsteps;
  logic       stop;
  logic [3:0] state;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  lfsr_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .seed   (seed),
    .nsteps (nsteps),
    .stop   (stop),
    .state  (state),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int md;
    int sd;
    int n;
    int stop_c;
    int poke_c;
    int ecount;
    int estate;
    int elen;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One LFSR step written arithmetically: shift right, parity of the two
  // low bits becomes the new weight-8 bit.
  function automatic int mstep(input int s);
    int fb;
    fb = (s ^ (s >> 1)) & 1;
    return (s >> 1) + fb * 8;
  endfunction

  function automatic int madv(input int s, input int n);
    int v;
    v = s;
    for (int i = 0; i < n; i++) v = mstep(v);
    return v;
  endfunction

  function automatic int mperiod(input int s);
    int v;
    int p;
    v = mstep(s);
    p = 1;
    while (v != s && p < 1000) begin
      v = mstep(v);
      p++;
    end
    return p;
  endfunction

  // Expected count, state and run length (cycles from LOAD to DONE) for a run.
  // stop_c is the cycle index after acceptance (0 = LOAD) where stop is high.
  task automatic model(input int md, input int sd, input int n, input int stop_c,
                       output int ecount, output int estate, output int elen);
    int natural_len;
    int shifts;
    if (md == 0) natural_len = n;
    else if (md == 1) natural_len = mperiod(sd);
    else natural_len = 1 << 30;
    if (md == 0 && n == 0) begin
      shifts = 0;
      elen   = 1;
    end else if (stop_c >= 1 && stop_c < natural_len) begin
      shifts = stop_c - 1;
      elen   = stop_c + 1;
    end else begin
      shifts = natural_len;
      elen   = natural_len + 1;
    end
    ecount = (shifts > 255) ? 255 : shifts;
    estate = madv(sd, shifts);
  endtask

  task automatic do_run(input string tag, input int md, input int sd, input int n,
                        input int stop_c, input int poke_c,
                        input int ecount, input int estate, input int elen);
    int c;
    int busy_cyc;
    int errs;
    bit got;
    mode   = 2'(md);
    seed   = 4'(sd);
    nsteps = 8'(n);
    stop   = 1'b0;
    start  = 1'b1;
    tick;
    start    = 1'b0;
    c        = 0;
    busy_cyc = 0;
    errs     = 0;
    got      = 1'b0;
    while (!got && c < 700) begin
      stop = (c == stop_c);
      if (c == poke_c) begin
        start  = 1'b1;
        seed   = 4'hF;
        nsteps = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (c == 1) check({tag, "_seed_loaded"}, state, sd);
      if (busy) busy_cyc++;
      if (err && !done) errs++;
      if (done) begin
        got = 1'b1;
        check({tag, "_count"}, count, ecount);
        check({tag, "_state"}, state, estate);
        check({tag, "_err_at_done"}, err, 0);
        check({tag, "_done_cycle"}, c, elen);
      end else begin
        tick;
        c++;
      end
    end
    if (!got) check({tag, "_done_seen"}, 0, 1);
    check({tag, "_busy_cycles"}, busy_cyc, elen);
    check({tag, "_stray_err"}, errs, 0);
    stop  = 1'b0;
    start = 1'b0;
    tick;
    check({tag, "_done_single"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec, es, el;
    int md, sd, n, sc, pc;
    logic [3:0] prev_state;
    logic [7:0] prev_count;
    int dones;

    //     md sd  n  stop poke cnt  st  len
    tbl[0]  = '{0, 8,  3,  -1,  2,   3,  9,   4};  // restart while busy ignored
    tbl[1]  = '{1, 8,  0,  -1, -1,  15,  8,  16};
    tbl[2]  = '{1, 6,  0,  -1, -1,  15,  6,  16};
    tbl[3]  = '{2, 1,  0,   6, -1,   5, 12,   7};
    tbl[4]  = '{0, 10, 0,  -1, -1,   0, 10,   1};  // nsteps = 0
    tbl[5]  = '{0, 8,  3,   3, -1,   3,  9,   4};  // stop on terminal shift loses
    tbl[6]  = '{0, 8,  3,   2, -1,   1,  4,   3};  // stop mid-run
    tbl[7]  = '{0, 1,  15, -1, -1,  15,  1,  16};
    tbl[8]  = '{2, 3,  0, 301, -1, 255,  3, 302};  // count saturation
    tbl[9]  = '{0, 8,  3,   0,  4,   3,  9,   4};  // stop in LOAD, start in DONE
    tbl[10] = '{1, 8,  0,   5, -1,   4, 12,   6};  // stop during period measure

    rst    = 1'b0;
    start  = 1'b1;
    stop   = 1'b1;
    mode   = 2'b00;
    seed   = 4'h5;
    nsteps = 8'd4;
    tick;
    tick;
    check("reset_state", state, 0);
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) begin
      do_run($sformatf("vec%0d", i), tbl[i].md, tbl[i].sd, tbl[i].n,
             tbl[i].stop_c, tbl[i].poke_c, tbl[i].ecount, tbl[i].estate, tbl[i].elen);
    end

    // Rejected starts: zero seed, then illegal mode.
    prev_state = state;
    prev_count = count;
    mode  = 2'b00;
    seed  = 4'h0;
    nsteps = 8'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("rej0_err", err, 1);
    check("rej0_busy", busy, 0);
    tick;
    check("rej0_err_clear", err, 0);
    check("rej0_busy_later", busy, 0);
    check("rej0_state", state, prev_state);
    check("rej0_count", count, prev_count);
    mode  = 2'b11;
    seed  = 4'h5;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("rej3_err", err, 1);
    check("rej3_busy", busy, 0);
    tick;
    check("rej3_err_clear", err, 0);
    check("rej3_busy_later", busy, 0);
    check("rej3_state", state, prev_state);
    check("rej3_count", count, prev_count);

    // Reset in the middle of a step-N run, with start and stop also high.
    mode   = 2'b00;
    seed   = 4'h8;
    nsteps = 8'd20;
    start  = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    check("mid_busy_before", busy, 1);
    rst   = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    tick;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) dones++;
      tick;
    end
    check("mid_rst_no_done", dones, 0);

    // Randomized runs against the model.
    for (int i = 0; i < 30; i++) begin
      md = int'($urandom_range(0, 2));
      sd = int'($urandom_range(1, 15));
      n  = int'($urandom_range(0, 40));
      sc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 45)) : -1;
      if (md == 2 && sc < 1) sc = int'($urandom_range(1, 45));
      pc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 50)) : -1;
      model(md, sd, n, sc, ec, es, el);
      do_run($sformatf("rnd%0d", i), md, sd, n, sc, pc, ec, es, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
